// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared constants for the lab CPU ALU.
//   - WIDTH   : operand width. The ALU result is 2*WIDTH bits wide.
//   - OP_*    : 5-bit opcode encodings. Any other encoding yields a zero result.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int WIDTH = 32;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_SHR = 5'b00101;
    localparam logic [4:0] OP_SHL = 5'b00110;
    localparam logic [4:0] OP_ROR = 5'b00111;
    localparam logic [4:0] OP_ROL = 5'b01000;
    localparam logic [4:0] OP_AND = 5'b01001;
    localparam logic [4:0] OP_OR  = 5'b01010;
    localparam logic [4:0] OP_MUL = 5'b01110;
    localparam logic [4:0] OP_DIV = 5'b01111;
    localparam logic [4:0] OP_NEG = 5'b10000;
    localparam logic [4:0] OP_NOT = 5'b10001;
    localparam logic [4:0] OP_BRN = 5'b10010;

endpackage

// File: rtl/booth_mult.sv
// -----------------------------------------------------------------------------
// booth_mult
//   Combinational signed WIDTH x WIDTH multiplier using radix-4 Booth recoding.
//   Ports:
//     a       in  WIDTH    multiplicand (two's complement)
//     b       in  WIDTH    multiplier   (two's complement)
//     product out 2*WIDTH  signed product a*b
// -----------------------------------------------------------------------------
module booth_mult
    import alu_pkg::*;
#(
    parameter int MW = WIDTH
) (
    input  logic [MW-1:0]   a,
    input  logic [MW-1:0]   b,
    output logic [2*MW-1:0] product
);

    localparam int DIGITS = MW / 2;

    // Multiplier with an implicit 0 below the LSB; each Booth digit looks at
    // an overlapping 3-bit window starting at an even bit position.
    logic [MW:0]     b_ext;
    logic [2*MW-1:0] a_x1;
    logic [2*MW-1:0] a_x2;

    assign b_ext = {b, 1'b0};
    assign a_x1  = {{MW{a[MW-1]}}, a};
    assign a_x2  = {a_x1[2*MW-2:0], 1'b0};

    logic [2*MW-1:0] pp;
    logic [2*MW-1:0] acc;

    always_comb begin
        acc = '0;
        pp  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            // Digit in {-2,-1,0,+1,+2}; the top window uses b's sign bit, so
            // the recoding is correct for a signed multiplier.
            case (b_ext[2*i +: 3])
                3'b001, 3'b010: pp = a_x1;
                3'b011:         pp = a_x2;
                3'b100:         pp = -a_x2;
                3'b101, 3'b110: pp = -a_x1;
                default:        pp = '0;
            endcase
            acc = acc + (pp << (2 * i));
        end
    end

    assign product = acc;

endmodule

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
//   Registered 32-bit ALU for the lab CPU. The result is 2*WIDTH wide so the
//   multiply product and divide quotient/remainder fit; LO = [WIDTH-1:0],
//   HI = [2*WIDTH-1:WIDTH]. Result appears one clock after the inputs.
//   Ports:
//     clk      in   1        system clock, rising edge
//     rst_n    in   1        asynchronous active-low reset (clears alu_out)
//     brn_flag in   WIDTH    branch condition, nonzero = taken
//     alu_in_a in   WIDTH    operand A (PC for BRN)
//     alu_in_b in   WIDTH    operand B (offset for BRN)
//     op_code  in   5        operation select
//     alu_out  out  2*WIDTH  registered result
// -----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int AW = WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   brn_flag,
    input  logic [AW-1:0]   alu_in_a,
    input  logic [AW-1:0]   alu_in_b,
    input  logic [4:0]      op_code,
    output logic [2*AW-1:0] alu_out
);

    localparam int SHW = $clog2(AW);

    logic [SHW-1:0]  shamt;
    logic [2*AW-1:0] dup_a;
    logic [2*AW-1:0] rot_r;
    logic [2*AW-1:0] rot_l;
    logic [2*AW-1:0] mul_p;

    // Only the low bits of B select the shift/rotate distance.
    assign shamt = alu_in_b[SHW-1:0];

    // Rotates shift a doubled copy of A so bits leaving one end re-enter the
    // other; a count of 0 naturally returns A.
    assign dup_a = {alu_in_a, alu_in_a};
    assign rot_r = dup_a >> shamt;
    assign rot_l = dup_a << shamt;

    booth_mult #(.MW(AW)) u_booth (
        .a       (alu_in_a),
        .b       (alu_in_b),
        .product (mul_p)
    );

    // Division. Zero divisor and the single overflowing case are overridden,
    // and the divisor fed to the operators is forced to 1 in those cases so
    // the operators never see an undefined division.
    logic div_zero;
    logic div_ovf;
    logic signed [AW-1:0] div_num;
    logic signed [AW-1:0] div_den;
    logic signed [AW-1:0] div_q;
    logic signed [AW-1:0] div_r;

    assign div_zero = (alu_in_b == '0);
    assign div_ovf  = (alu_in_a == {1'b1, {(AW-1){1'b0}}}) && (alu_in_b == '1);
    assign div_num  = alu_in_a;
    assign div_den  = (div_zero || div_ovf) ? AW'(1) : alu_in_b;
    assign div_q    = div_num / div_den;
    assign div_r    = div_num % div_den;

    logic [AW-1:0]   lo;
    logic [AW-1:0]   hi;
    logic [2*AW-1:0] result;

    always_comb begin
        lo     = '0;
        hi     = '0;
        result = '0;
        case (op_code)
            OP_ADD: lo = alu_in_a + alu_in_b;
            OP_SUB: lo = alu_in_a - alu_in_b;
            OP_SHR: lo = alu_in_a >> shamt;
            OP_SHL: lo = alu_in_a << shamt;
            OP_ROR: lo = rot_r[AW-1:0];
            OP_ROL: lo = rot_l[2*AW-1:AW];
            OP_AND: lo = alu_in_a & alu_in_b;
            OP_OR:  lo = alu_in_a | alu_in_b;
            OP_MUL: {hi, lo} = mul_p;
            OP_DIV: begin
                if (div_zero) begin
                    lo = '1;
                    hi = alu_in_a;
                end else if (div_ovf) begin
                    lo = alu_in_a;
                    hi = '0;
                end else begin
                    lo = div_q;
                    hi = div_r;
                end
            end
            OP_NEG: lo = '0 - alu_in_b;
            OP_NOT: lo = ~alu_in_b;
            OP_BRN: lo = (brn_flag != '0) ? (alu_in_a + alu_in_b) : alu_in_a;
            default: lo = '0;
        endcase
        result = {hi, lo};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) alu_out <= '0;
        else        alu_out <= result;
    end

endmodule

// File: tb/tb_alu_core.sv
module tb_alu_core;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] brn_flag;
    logic [31:0] alu_in_a;
    logic [31:0] alu_in_b;
    logic [4:0]  op_code;
    logic [63:0] alu_out;

    int checks = 0;
    int errors = 0;

    logic [63:0] sb_exp[$];
    string       sb_name[$];

    alu_core dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .brn_flag (brn_flag),
        .alu_in_a (alu_in_a),
        .alu_in_b (alu_in_b),
        .op_code  (op_code),
        .alu_out  (alu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] f;
        logic [63:0] e;
    } vec_t;

    // Drive one operation and record what the register must hold after the next edge.
    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] f, input logic [63:0] e, input string name);
        op_code  = op;
        alu_in_a = a;
        alu_in_b = b;
        brn_flag = f;
        sb_exp.push_back(e);
        sb_name.push_back(name);
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb_;
        sa  = {{32{a[31]}}, a};
        sb_ = {{32{b[31]}}, b};
        return sa * sb_;
    endfunction

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
    endfunction

    task automatic test_reset();
        logic [63:0] e;
        string       n;
        rst_n = 1'b0;
        op_code = OP_ADD; alu_in_a = 32'd10; alu_in_b = 32'd2; brn_flag = 32'd0;
        repeat (2) begin
            @(posedge clk); #1;
            checks++;
            if (alu_out !== 64'd0) begin
                errors++;
                $display("FAIL reset_hold: got %h want %h", alu_out, 64'd0);
            end
        end
        #2 rst_n = 1'b1;
        drive(OP_ADD, 32'd10, 32'd2, 32'd0, 64'd12, "reset_release_add");
        @(posedge clk); #1;
        e = sb_exp.pop_front(); n = sb_name.pop_front();
        checks++;
        if (alu_out !== e) begin
            errors++;
            $display("FAIL %s: got %h want %h", n, alu_out, e);
        end
        // Mid-cycle reset clears without an edge and discards the pending op.
        drive(OP_SUB, 32'd10, 32'd2, 32'd0, 64'd0, "unused");
        void'(sb_exp.pop_back()); void'(sb_name.pop_back());
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (alu_out !== 64'd0) begin
            errors++;
            $display("FAIL reset_async: got %h want %h", alu_out, 64'd0);
        end
        @(posedge clk); #1;
        checks++;
        if (alu_out !== 64'd0) begin
            errors++;
            $display("FAIL reset_discard: got %h want %h", alu_out, 64'd0);
        end
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_arith();
        vec_t        v[$];
        logic [63:0] e;
        string       n;
        v.push_back('{"add",       OP_ADD, 32'd10, 32'd2, 32'd0, 64'd12});
        v.push_back('{"sub",       OP_SUB, 32'd10, 32'd2, 32'd0, 64'd8});
        v.push_back('{"sub_wrap",  OP_SUB, 32'd2, 32'd10, 32'd0, 64'h0000_0000_FFFF_FFF8});
        v.push_back('{"add_carry", OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 64'd0});
        v.push_back('{"mul",       OP_MUL, 32'd10, 32'd2, 32'd0, 64'd20});
        v.push_back('{"div",       OP_DIV, 32'd10, 32'd2, 32'd0, 64'd5});
        v.push_back('{"div_neg",   OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 64'hFFFF_FFFF_FFFF_FFFD});
        v.push_back('{"div_zero",  OP_DIV, 32'd10, 32'd0, 32'd0, 64'h0000_000A_FFFF_FFFF});
        v.push_back('{"div_ovf",   OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 64'h0000_0000_8000_0000});
        v.push_back('{"mul_neg",   OP_MUL, 32'hFFFF_FFFD, 32'd5, 32'd0, 64'hFFFF_FFFF_FFFF_FFF1});
        v.push_back('{"mul_minmin", OP_MUL, 32'h8000_0000, 32'h8000_0000, 32'd0, 64'h4000_0000_0000_0000});
        v.push_back('{"mul_m1m1",  OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 64'd1});
        foreach (v[i]) begin
            drive(v[i].op, v[i].a, v[i].b, v[i].f, v[i].e, v[i].name);
            @(posedge clk); #1;
            e = sb_exp.pop_front(); n = sb_name.pop_front();
            checks++;
            if (alu_out !== e) begin
                errors++;
                $display("FAIL %s: got %h want %h", n, alu_out, e);
            end
        end
    endtask

    task automatic test_logic();
        vec_t        v[$];
        logic [63:0] e;
        string       n;
        v.push_back('{"and", OP_AND, 32'd10, 32'd2, 32'd0, 64'd2});
        v.push_back('{"or",  OP_OR,  32'd10, 32'd2, 32'd0, 64'd10});
        v.push_back('{"neg", OP_NEG, 32'd10, 32'd2, 32'd0, 64'h0000_0000_FFFF_FFFE});
        v.push_back('{"not", OP_NOT, 32'd10, 32'd2, 32'd0, 64'h0000_0000_FFFF_FFFD});
        foreach (v[i]) begin
            drive(v[i].op, v[i].a, v[i].b, v[i].f, v[i].e, v[i].name);
            @(posedge clk); #1;
            e = sb_exp.pop_front(); n = sb_name.pop_front();
            checks++;
            if (alu_out !== e) begin
                errors++;
                $display("FAIL %s: got %h want %h", n, alu_out, e);
            end
        end
    endtask

    task automatic test_shift();
        vec_t        v[$];
        logic [63:0] e;
        string       n;
        v.push_back('{"shr",      OP_SHR, 32'h8000_0001, 32'd4,    32'd0, 64'h0800_0000});
        v.push_back('{"shl",      OP_SHL, 32'h8000_0001, 32'd4,    32'd0, 64'h0000_0010});
        v.push_back('{"ror",      OP_ROR, 32'h8000_0001, 32'd4,    32'd0, 64'h1800_0000});
        v.push_back('{"rol",      OP_ROL, 32'h8000_0001, 32'd4,    32'd0, 64'h0000_0018});
        v.push_back('{"shr_hi",   OP_SHR, 32'h8000_0001, 32'h24,   32'd0, 64'h0800_0000});
        v.push_back('{"shl_hi",   OP_SHL, 32'h8000_0001, 32'h24,   32'd0, 64'h0000_0010});
        v.push_back('{"ror_hi",   OP_ROR, 32'h8000_0001, 32'h24,   32'd0, 64'h1800_0000});
        v.push_back('{"rol_hi",   OP_ROL, 32'h8000_0001, 32'h24,   32'd0, 64'h0000_0018});
        v.push_back('{"ror_zero", OP_ROR, 32'h8000_0001, 32'd0,    32'd0, 64'h8000_0001});
        v.push_back('{"shl_32",   OP_SHL, 32'h8000_0001, 32'd32,   32'd0, 64'h8000_0001});
        v.push_back('{"rol_31",   OP_ROL, 32'h8000_0001, 32'd31,   32'd0, 64'hC000_0000});
        foreach (v[i]) begin
            drive(v[i].op, v[i].a, v[i].b, v[i].f, v[i].e, v[i].name);
            @(posedge clk); #1;
            e = sb_exp.pop_front(); n = sb_name.pop_front();
            checks++;
            if (alu_out !== e) begin
                errors++;
                $display("FAIL %s: got %h want %h", n, alu_out, e);
            end
        end
    endtask

    task automatic test_branch_default();
        vec_t        v[$];
        logic [63:0] e;
        string       n;
        v.push_back('{"brn_not",   OP_BRN, 32'd100, 32'd20, 32'd0,         64'd100});
        v.push_back('{"brn_taken", OP_BRN, 32'd100, 32'd20, 32'd1,         64'd120});
        v.push_back('{"brn_hiflg", OP_BRN, 32'd100, 32'd20, 32'h8000_0000, 64'd120});
        v.push_back('{"op_00000",  5'b00000, 32'd10, 32'd2, 32'd1,         64'd0});
        v.push_back('{"op_11111",  5'b11111, 32'd10, 32'd2, 32'd1,         64'd0});
        v.push_back('{"op_01011",  5'b01011, 32'd10, 32'd2, 32'd1,         64'd0});
        v.push_back('{"op_x",      5'bxxxxx, 32'd10, 32'd2, 32'd1,         64'd0});
        foreach (v[i]) begin
            drive(v[i].op, v[i].a, v[i].b, v[i].f, v[i].e, v[i].name);
            @(posedge clk); #1;
            e = sb_exp.pop_front(); n = sb_name.pop_front();
            checks++;
            if (alu_out !== e) begin
                errors++;
                $display("FAIL %s: got %h want %h", n, alu_out, e);
            end
        end
    endtask

    task automatic test_random_muldiv();
        logic [31:0] a, b;
        logic [63:0] e;
        string       n;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = (i % 8 == 7) ? 32'd0 : $urandom;
            if (i % 4 == 3) b = b & 32'h0000_00FF;
            if (i % 2 == 0) drive(OP_MUL, a, b, 32'd0, ref_mul(a, b), "rand_mul");
            else            drive(OP_DIV, a, b, 32'd0, ref_div(a, b), "rand_div");
            @(posedge clk); #1;
            e = sb_exp.pop_front(); n = sb_name.pop_front();
            checks++;
            if (alu_out !== e) begin
                errors++;
                $display("FAIL %s: a=%h b=%h got %h want %h", n, a, b, alu_out, e);
            end
        end
    endtask

    // Keep a new op in flight every cycle: each edge retires the previous op.
    task automatic test_back_to_back();
        vec_t        v[$];
        logic [63:0] e;
        string       n;
        v.push_back('{"b2b_add", OP_ADD, 32'd7,   32'd5, 32'd0, 64'd12});
        v.push_back('{"b2b_sub", OP_SUB, 32'd7,   32'd5, 32'd0, 64'd2});
        v.push_back('{"b2b_mul", OP_MUL, 32'd7,   32'd5, 32'd0, 64'd35});
        v.push_back('{"b2b_shl", OP_SHL, 32'd7,   32'd5, 32'd0, 64'd224});
        v.push_back('{"b2b_brn", OP_BRN, 32'd200, 32'd8, 32'd3, 64'd208});
        v.push_back('{"b2b_def", 5'b10111, 32'd7, 32'd5, 32'd0, 64'd0});
        v.push_back('{"b2b_or",  OP_OR,  32'd7,   32'd8, 32'd0, 64'd15});
        drive(v[0].op, v[0].a, v[0].b, v[0].f, v[0].e, v[0].name);
        for (int i = 1; i <= v.size(); i++) begin
            @(posedge clk); #1;
            e = sb_exp.pop_front(); n = sb_name.pop_front();
            checks++;
            if (alu_out !== e) begin
                errors++;
                $display("FAIL %s: got %h want %h", n, alu_out, e);
            end
            if (i < v.size()) drive(v[i].op, v[i].a, v[i].b, v[i].f, v[i].e, v[i].name);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        op_code  = 5'd0;
        alu_in_a = 32'd0;
        alu_in_b = 32'd0;
        brn_flag = 32'd0;
        #1;
        checks++;
        if (alu_out !== 64'd0) begin
            errors++;
            $display("FAIL reset_initial: got %h want %h", alu_out, 64'd0);
        end
        test_reset();
        test_arith();
        test_logic();
        test_shift();
        test_branch_default();
        test_random_muldiv();
        test_back_to_back();
        checks++;
        if (sb_exp.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sb_exp.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
